// File: rtl/axis_tx_pkt_fifo.sv
// Store-and-forward 512-bit AXI4-Stream packet FIFO feeding the TX LBUS converter.
// Optional feature: define TX_FIFO_BAD_PKT_DROP_EN to drop packets flagged by s_axis_tuser on tlast.
module axis_tx_pkt_fifo #(
  parameter int DEPTH      = 64,
  parameter int DROP_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [511:0]             s_axis_tdata,
  input  logic [63:0]              s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tuser,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [511:0]             m_axis_tdata,
  output logic [63:0]              m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [DROP_CNT_W-1:0]    drop_count,
  output logic                     drop_pulse
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BEAT_W = 512 + 64 + 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {WR_IDLE, WR_WRITE, WR_DISCARD} wr_state_t;
  typedef enum logic {RD_IDLE, RD_SEND} rd_state_t;

  logic [BEAT_W-1:0] mem [DEPTH];
  logic [BEAT_W-1:0] out_q;

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic [ADDR_W:0] wr_ptr, wr_commit, rd_ptr, fetch_ptr, beat_cnt, beat_next, occ;
  logic s_fire, store, bad_pkt, commit, drop_big, drop_bad, drop_any;
  logic out_fire, out_free, out_last_fire, avail, rd_issue;

`ifdef TX_FIFO_BAD_PKT_DROP_EN
  assign bad_pkt = s_axis_tuser;
`else
  logic unused_tuser;
  assign unused_tuser = s_axis_tuser;
  assign bad_pkt = 1'b0;
`endif

  assign occ           = wr_ptr - rd_ptr;
  assign occupancy     = occ;
  assign s_axis_tready = !rst && ((wr_state == WR_DISCARD) || (occ != DEPTH_V));
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign store         = s_fire && (wr_state != WR_DISCARD);
  assign beat_next     = (wr_state == WR_IDLE) ? (ADDR_W+1)'(1) : beat_cnt + 1'b1;

  assign commit   = store && s_axis_tlast && !bad_pkt;
  assign drop_bad = store && s_axis_tlast && bad_pkt;
  assign drop_big = store && !s_axis_tlast && (beat_next == DEPTH_V);
  assign drop_any = drop_big || drop_bad;

  always_ff @(posedge clk) begin
    if (store)
      mem[wr_ptr[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  // Beats land speculatively at wr_ptr; only a clean tlast moves wr_commit, a drop rewinds to it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state   <= WR_IDLE;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      beat_cnt   <= '0;
      drop_count <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop_any;
      if (drop_any && (drop_count != {DROP_CNT_W{1'b1}}))
        drop_count <= drop_count + 1'b1;
      case (wr_state)
        WR_IDLE, WR_WRITE: begin
          if (store) begin
            if (drop_any) begin
              wr_ptr   <= wr_commit;
              wr_state <= drop_big ? WR_DISCARD : WR_IDLE;
            end else if (s_axis_tlast) begin
              wr_ptr    <= wr_ptr + 1'b1;
              wr_commit <= wr_ptr + 1'b1;
              wr_state  <= WR_IDLE;
            end else begin
              wr_ptr   <= wr_ptr + 1'b1;
              beat_cnt <= beat_next;
              wr_state <= WR_WRITE;
            end
          end
        end
        WR_DISCARD: begin
          if (s_fire && s_axis_tlast)
            wr_state <= WR_IDLE;
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  assign out_fire      = m_axis_tvalid && m_axis_tready;
  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign out_last_fire = out_fire && m_axis_tlast;
  assign avail         = (fetch_ptr != wr_commit);
  assign rd_issue      = avail && ((rd_state == RD_IDLE) ? !m_axis_tvalid : out_free);

  // The RAM read register doubles as the read-ahead output stage: it reloads in the
  // same cycle the current beat is taken, so committed beats stream with no bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state      <= RD_IDLE;
      fetch_ptr     <= '0;
      rd_ptr        <= '0;
      out_q         <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (rd_issue) begin
        out_q         <= mem[fetch_ptr[ADDR_W-1:0]];
        fetch_ptr     <= fetch_ptr + 1'b1;
        m_axis_tvalid <= 1'b1;
      end else if (out_fire) begin
        m_axis_tvalid <= 1'b0;
      end
      if (out_fire)
        rd_ptr <= rd_ptr + 1'b1;
      case (rd_state)
        RD_IDLE: if (rd_issue) rd_state <= RD_SEND;
        RD_SEND: if (out_last_fire && !rd_issue) rd_state <= RD_IDLE;
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
    end else begin
      case ({commit, out_last_fire})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  assign m_axis_tdata = out_q[511:0];
  assign m_axis_tkeep = out_q[575:512];
  assign m_axis_tlast = out_q[576];

endmodule

// File: tb/tb_axis_tx_pkt_fifo.sv
// Self-checking bench for axis_tx_pkt_fifo (DEPTH=8): directed scenarios plus random packets
// checked every cycle against a queue-based packet model.
module tb_axis_tx_pkt_fifo;

  localparam int DEPTH      = 8;
  localparam int DROP_CNT_W = 16;
`ifdef TX_FIFO_BAD_PKT_DROP_EN
  localparam bit BAD_EN = 1'b1;
`else
  localparam bit BAD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tlast, s_axis_tuser, s_axis_tvalid, s_axis_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [3:0]   pkt_count, occupancy;
  logic [DROP_CNT_W-1:0] drop_count;
  logic         drop_pulse;

  axis_tx_pkt_fifo #(.DEPTH(DEPTH), .DROP_CNT_W(DROP_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .pkt_count(pkt_count), .occupancy(occupancy), .drop_count(drop_count), .drop_pulse(drop_pulse)
  );

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  // Packet-level model: partial packet, committed-but-unpresented beats, presented beat.
  beat_t part_q[$];
  beat_t commit_q[$];
  beat_t out_exp;
  bit    valid_exp, discarding, pulse_exp, post_rst, model_ok;
  int    occ_exp, pkt_exp, drop_exp;
  int    tests, fails;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input logic r);
    check("s_tready", s_axis_tready, !r && (discarding || occ_exp != DEPTH));
    if (!r) begin
      check("m_tvalid", m_axis_tvalid, valid_exp);
      if (valid_exp) begin
        check("m_tdata", m_axis_tdata, out_exp.data);
        check("m_tkeep", m_axis_tkeep, out_exp.keep);
        check("m_tlast", m_axis_tlast, out_exp.last);
      end
      if (post_rst) begin
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tkeep", m_axis_tkeep, 0);
        check("rst_tlast", m_axis_tlast, 0);
      end
      check("occupancy", occupancy, occ_exp);
      check("pkt_count", pkt_count, pkt_exp);
      check("drop_count", drop_count, drop_exp);
      check("drop_pulse", drop_pulse, pulse_exp);
    end
  endtask

  task automatic model_update(input logic v, input beat_t b, input logic u, input logic mr,
                              input logic r, output bit acc);
    bit dropped;
    if (r) begin
      part_q.delete();
      commit_q.delete();
      valid_exp = 0; discarding = 0; pulse_exp = 0;
      occ_exp = 0; pkt_exp = 0; drop_exp = 0;
      post_rst = 1; model_ok = 1; acc = 0;
      return;
    end
    post_rst = 0;
    dropped  = 0;
    acc = v && (discarding || occ_exp != DEPTH);
    if (valid_exp && mr) begin
      occ_exp--;
      if (out_exp.last) pkt_exp--;
    end
    if (!valid_exp || mr) begin
      if (commit_q.size() > 0) begin
        out_exp   = commit_q.pop_front();
        valid_exp = 1;
      end else begin
        valid_exp = 0;
      end
    end
    if (acc) begin
      if (discarding) begin
        if (b.last) discarding = 0;
      end else begin
        part_q.push_back(b);
        occ_exp++;
        if (b.last) begin
          if (u && BAD_EN) begin
            occ_exp -= part_q.size();
            dropped = 1;
          end else begin
            foreach (part_q[i]) commit_q.push_back(part_q[i]);
            pkt_exp++;
          end
          part_q.delete();
        end else if (part_q.size() == DEPTH) begin
          occ_exp -= DEPTH;
          dropped = 1;
          discarding = 1;
          part_q.delete();
        end
      end
    end
    if (dropped) drop_exp++;
    pulse_exp = dropped;
  endtask

  task automatic apply_stimulus(input logic v, input beat_t b, input logic u, input logic mr,
                                input logic r, output bit acc);
    @(negedge clk);
    s_axis_tvalid = v;
    s_axis_tdata  = b.data;
    s_axis_tkeep  = b.keep;
    s_axis_tlast  = b.last;
    s_axis_tuser  = u;
    m_axis_tready = mr;
    rst           = r;
    #1;
    if (model_ok || r) check_output(r);
    model_update(v, b, u, mr, r, acc);
  endtask

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    logic [63:0] ones;
    ones = '1;
    for (int j = 0; j < 16; j++) b.data[j*32 +: 32] = $urandom();
    b.keep = last ? (ones >> $urandom_range(0, 63)) : ones;
    b.last = last;
    return b;
  endfunction

  task automatic idle(input int n, input logic mr);
    bit acc;
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, rand_beat(1'b0), 1'b0, mr, 1'b0, acc);
  endtask

  task automatic send_pkt(input int len, input int gap_pct, input int mr_pct, input bit bad);
    beat_t b;
    bit acc;
    int tries;
    for (int i = 0; i < len; i++) begin
      b = rand_beat(i == len - 1);
      acc = 0;
      tries = 0;
      while (!acc && tries < 200) begin
        apply_stimulus($urandom_range(0, 99) >= gap_pct, b, bad && b.last,
                       $urandom_range(0, 99) < mr_pct, 1'b0, acc);
        tries++;
      end
      check("send_timeout", acc, 1'b1);
    end
  endtask

  initial begin
    beat_t b;
    bit acc;
    int n;
    tests = 0; fails = 0; model_ok = 0;
    rst = 1'b1; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;

    apply_stimulus(1'b0, rand_beat(1'b0), 1'b0, 1'b0, 1'b1, acc);
    apply_stimulus(1'b0, rand_beat(1'b0), 1'b0, 1'b0, 1'b1, acc);
    idle(2, 1'b1);

    // Single-beat packet with upper-bytes keep
    b = rand_beat(1'b1);
    b.keep = 64'hFFFF_0000_0000_0000;
    apply_stimulus(1'b1, b, 1'b0, 1'b1, 1'b0, acc);
    check("s1_accept", acc, 1'b1);
    idle(5, 1'b1);

    // Three beats with valid gaps
    for (int i = 0; i < 5; i++)
      apply_stimulus(i % 2 == 0, rand_beat(i == 4), 1'b0, 1'b1, 1'b0, acc);
    idle(6, 1'b1);

    // Oversize packet dropped, then a normal one
    send_pkt(9, 0, 100, 1'b0);
    send_pkt(2, 0, 100, 1'b0);
    idle(6, 1'b1);
    check("s3_drop_count", drop_count, 1);

    // Fill with output stalled, then drain
    send_pkt(4, 0, 0, 1'b0);
    send_pkt(4, 0, 0, 1'b0);
    idle(3, 1'b0);
    check("s4_full_ready", s_axis_tready, 1'b0);
    check("s4_full_pkts", pkt_count, 2);
    idle(12, 1'b1);
    check("s4_ready_back", s_axis_tready, 1'b1);

    // Bad packet then good packet
    send_pkt(2, 0, 100, 1'b1);
    send_pkt(3, 0, 100, 1'b0);
    idle(8, 1'b1);
    check("s5_drop_count", drop_count, 1 + int'(BAD_EN));

    // Reset while packet 1 streams and packet 2 is partial
    send_pkt(5, 0, 100, 1'b0);
    apply_stimulus(1'b1, rand_beat(1'b0), 1'b0, 1'b1, 1'b0, acc);
    apply_stimulus(1'b1, rand_beat(1'b0), 1'b0, 1'b1, 1'b0, acc);
    check("s6_streaming", m_axis_tvalid, 1'b1);
    apply_stimulus(1'b1, rand_beat(1'b0), 1'b0, 1'b1, 1'b1, acc);
    idle(1, 1'b1);
    send_pkt(3, 0, 100, 1'b0);
    idle(8, 1'b1);

    // Random packets with random gaps, back-pressure and bad flags
    for (int p = 0; p < 40; p++)
      send_pkt($urandom_range(1, 10), 30, 70, $urandom_range(0, 99) < 20);
    n = 0;
    while ((valid_exp || commit_q.size() > 0) && n < 200) begin
      idle(1, 1'b1);
      n++;
    end
    check("drain_timeout", valid_exp || commit_q.size() > 0, 1'b0);
    idle(2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
